wdt_rstgen: RTL and testbench
=============================

WDT_RSTGEN -- requirements
Module: wdt_rstgen

Interface
REQ-001 The block SHALL have parameter RST_PULSE, default 4, number of cycles soft_rst_en is held high on timeout (legal 1..15).
REQ-002 The block SHALL have parameter FEED_KEY, default 32'h5A5A_A5A5, value a FEED write must carry to reload the counter.
REQ-003 clk  input  1  system clock; all logic on its rising edge.
REQ-004 rst_n  input  1  synchronous active-low reset.
REQ-005 we_i  input  1  register write strobe, one write per cycle.
REQ-006 addr_i  input  2  register word index: 0 CTRL, 1 LOAD, 2 FEED, 3 COUNT.
REQ-007 wdata_i  input  32  write data.
REQ-008 rdata_o  output  32  read data for the addr_i sampled on the previous cycle.
REQ-009 irq_o  output  1  warning interrupt, level.
REQ-010 soft_rst_en  output  1  software-reset request to the reset controller, active high.

Function
REQ-011 CTRL SHALL hold EN (bit0), IRQ_EN (bit1) and STS (bit2, warning pending); EN and IRQ_EN are R/W, STS is write-1-to-clear, and other bits read 0.
REQ-012 LOAD SHALL be a 32-bit R/W timeout value; a write while counting SHALL take effect only at the next reload.
REQ-013 A FEED write with wdata_i == FEED_KEY SHALL be a valid feed; any other FEED value SHALL be ignored; FEED SHALL read 0.
REQ-014 COUNT SHALL be read-only and return the current down-counter value; writes are ignored.
REQ-015 rdata_o SHALL be registered: one-cycle read latency, independent of we_i.
REQ-016 The FSM SHALL have states IDLE, RUN, WARN and RST.
REQ-017 IDLE: counter holds its value; a CTRL write setting EN=1 SHALL load the counter with LOAD and enter RUN on the next cycle.
REQ-018 RUN/WARN: the counter SHALL decrement by 1 each cycle; counter == 0 at a clock edge SHALL be an expiry.
REQ-019 Expiry in RUN SHALL set STS, reload the counter from LOAD and enter WARN.
REQ-020 Expiry in WARN SHALL enter RST, clearing EN.
REQ-021 A valid feed in RUN or WARN SHALL reload the counter from LOAD and enter RUN; STS SHALL remain set until cleared by software.
REQ-022 A feed and an expiry in the same cycle SHALL resolve in favour of the feed.
REQ-023 A CTRL write with EN=0 in RUN or WARN SHALL enter IDLE with the counter frozen.
REQ-024 RST: soft_rst_en SHALL be 1 for exactly RST_PULSE cycles, then the FSM SHALL return to IDLE; all register writes SHALL be ignored during RST.
REQ-025 soft_rst_en SHALL be registered and SHALL be 1 only in RST.
REQ-026 irq_o SHALL equal STS & IRQ_EN, registered.
REQ-027 LOAD = 0 SHALL cause an expiry on the first counting cycle.
REQ-028 Clearing STS and an expiry setting STS in the same cycle SHALL leave STS = 1.

Reset
REQ-029 rst_n low at a clock edge SHALL force: state IDLE, EN=0, IRQ_EN=0, STS=0, LOAD=32'h00FF_FFFF, counter=32'h00FF_FFFF, rdata_o=0, irq_o=0, soft_rst_en=0.
REQ-030 Reset asserted mid-RST SHALL terminate the soft_rst_en pulse on the next edge.
REQ-031 No output SHALL change on an rst_n edge alone; only clock edges apply reset.

Verification
REQ-032 Write LOAD=10, then CTRL=3 -> STS=1 and irq_o=1 about 11 cycles later; a further 11 cycles with no feed -> soft_rst_en high for 4 cycles, then IDLE with EN=0.
REQ-033 In RUN with LOAD=10, write FEED=0x5A5AA5A5 every 8 cycles for 100 cycles -> STS, irq_o and soft_rst_en all stay 0.
REQ-034 Write FEED=0x12345678 in RUN -> counter is not reloaded and expiry occurs on schedule.
REQ-035 In WARN, issue a valid feed in the cycle the counter reads 0 -> state RUN, counter=LOAD, no soft_rst_en, STS still 1; write CTRL=3|4 -> STS=0 and irq_o=0.
REQ-036 LOAD=0 with EN set -> WARN on the first counting cycle; rst_n low during RST -> soft_rst_en=0 next cycle and all registers at reset values.
REQ-037 Write EN=0 in RUN -> COUNT frozen over 20 cycles; re-enable -> COUNT reloads to LOAD.

Source files
------------

// File: rtl/wdt_rstgen.sv
// Watchdog timer with a two-stage timeout: the first expiry raises a warning,
// the second requests a fixed-length software reset pulse.
module wdt_rstgen #(
    parameter int          RST_PULSE = 4,
    parameter logic [31:0] FEED_KEY  = 32'h5A5A_A5A5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        we_i,
    input  logic [1:0]  addr_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] rdata_o,
    output logic        irq_o,
    output logic        soft_rst_en,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        WARN = 2'd2,
        RST  = 2'd3
    } state_t;

    localparam logic [31:0] LOAD_RST = 32'h00FF_FFFF;

    state_t      state;
    logic        en;
    logic        irq_en;
    logic        sts;
    logic [31:0] load_q;
    logic [31:0] counter;
    logic [3:0]  rst_cnt;

    logic        wr_ctrl;
    logic        wr_load;
    logic        feed_ok;
    logic        counting;
    logic        disable_req;
    logic        expiry;
    logic        sts_nxt;
    logic        irq_en_nxt;
    logic [31:0] rd_mux;

    // Register writes are blocked entirely while the reset pulse is active.
    always_comb begin
        wr_ctrl     = we_i && (addr_i == 2'd0) && (state != RST);
        wr_load     = we_i && (addr_i == 2'd1) && (state != RST);
        feed_ok     = we_i && (addr_i == 2'd2) && (state != RST) && (wdata_i == FEED_KEY);
        counting    = (state == RUN) || (state == WARN);
        disable_req = counting && wr_ctrl && !wdata_i[0];
        // Disable and feed both take precedence over a same-cycle expiry.
        expiry      = counting && (counter == 32'd0) && !feed_ok && !disable_req;
        irq_en_nxt  = wr_ctrl ? wdata_i[1] : irq_en;
        sts_nxt     = (sts && !(wr_ctrl && wdata_i[2])) || (expiry && (state == RUN));
    end

    always_comb begin
        rd_mux = 32'd0;
        case (addr_i)
            2'd0:    rd_mux = {29'd0, sts, irq_en, en};
            2'd1:    rd_mux = load_q;
            2'd2:    rd_mux = 32'd0;
            default: rd_mux = counter;
        endcase
    end

    assign dbg_state = state;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            en          <= 1'b0;
            irq_en      <= 1'b0;
            sts         <= 1'b0;
            load_q      <= LOAD_RST;
            counter     <= LOAD_RST;
            rst_cnt     <= 4'd0;
            rdata_o     <= 32'd0;
            irq_o       <= 1'b0;
            soft_rst_en <= 1'b0;
        end else begin
            rdata_o <= rd_mux;
            irq_en  <= irq_en_nxt;
            sts     <= sts_nxt;
            irq_o   <= sts_nxt && irq_en_nxt;
            if (wr_ctrl) begin
                en <= wdata_i[0];
            end
            if (wr_load) begin
                load_q <= wdata_i;
            end

            case (state)
                IDLE: begin
                    if (wr_ctrl && wdata_i[0]) begin
                        counter <= load_q;
                        state   <= RUN;
                    end
                end
                RUN, WARN: begin
                    if (disable_req) begin
                        state <= IDLE;
                    end else if (feed_ok) begin
                        counter <= load_q;
                        state   <= RUN;
                    end else if (expiry) begin
                        if (state == RUN) begin
                            counter <= load_q;
                            state   <= WARN;
                        end else begin
                            en          <= 1'b0;
                            soft_rst_en <= 1'b1;
                            rst_cnt     <= 4'(RST_PULSE - 1);
                            state       <= RST;
                        end
                    end else begin
                        counter <= counter - 32'd1;
                    end
                end
                RST: begin
                    if (rst_cnt == 4'd0) begin
                        soft_rst_en <= 1'b0;
                        state       <= IDLE;
                    end else begin
                        rst_cnt <= rst_cnt - 4'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wdt_rstgen.sv
// Directed bench for wdt_rstgen: register access, two-stage expiry, feeding,
// disable/re-enable and reset during the reset pulse.
module tb_wdt_rstgen;

    localparam logic [31:0] KEY = 32'h5A5A_A5A5;
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_WARN = 2'd2;
    localparam logic [1:0] S_RST  = 2'd3;

    logic        clk;
    logic        rst_n;
    logic        we_i;
    logic [1:0]  addr_i;
    logic [31:0] wdata_i;
    logic [31:0] rdata_o;
    logic        irq_o;
    logic        soft_rst_en;
    logic [1:0]  dbg_state;

    int n_cmp;
    int n_err;
    logic soft_seen;
    logic irq_seen;
    logic [31:0] rd_val;

    wdt_rstgen #(.RST_PULSE(4), .FEED_KEY(KEY)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .we_i        (we_i),
        .addr_i      (addr_i),
        .wdata_i     (wdata_i),
        .rdata_o     (rdata_o),
        .irq_o       (irq_o),
        .soft_rst_en (soft_rst_en),
        .dbg_state   (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (soft_rst_en) soft_seen = 1'b1;
        if (irq_o) irq_seen = 1'b1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Called at a negedge; the write lands on the following rising edge.
    task automatic write(input logic [1:0] a, input logic [31:0] d);
        we_i    = 1'b1;
        addr_i  = a;
        wdata_i = d;
        @(negedge clk);
        we_i    = 1'b0;
        wdata_i = 32'd0;
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] d);
        we_i   = 1'b0;
        addr_i = a;
        @(negedge clk);
        d = rdata_o;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        soft_seen = 1'b0;
        irq_seen = 1'b0;
        rst_n = 1'b0;
        we_i = 1'b0;
        addr_i = 2'd0;
        wdata_i = 32'd0;

        // Reset state
        tick(2);
        check("rst_rdata", rdata_o, 32'd0);
        check("rst_irq", {31'd0, irq_o}, 32'd0);
        check("rst_soft", {31'd0, soft_rst_en}, 32'd0);
        check("rst_state", {30'd0, dbg_state}, {30'd0, S_IDLE});
        rst_n = 1'b1;
        rd(2'd1, rd_val); check("rst_load", rd_val, 32'h00FF_FFFF);
        rd(2'd3, rd_val); check("rst_count", rd_val, 32'h00FF_FFFF);
        rd(2'd0, rd_val); check("rst_ctrl", rd_val, 32'd0);
        rd(2'd2, rd_val); check("feed_reads_0", rd_val, 32'd0);

        // Two-stage timeout with LOAD=10
        write(2'd1, 32'd10);
        write(2'd0, 32'd3);
        check("t1_run", {30'd0, dbg_state}, {30'd0, S_RUN});
        tick(10);
        check("t1_pre_irq", {31'd0, irq_o}, 32'd0);
        check("t1_pre_state", {30'd0, dbg_state}, {30'd0, S_RUN});
        tick(1);
        check("t1_irq", {31'd0, irq_o}, 32'd1);
        check("t1_warn", {30'd0, dbg_state}, {30'd0, S_WARN});
        rd(2'd0, rd_val); check("t1_ctrl_sts", rd_val, 32'd7);
        tick(9);
        check("t1_pre_soft", {31'd0, soft_rst_en}, 32'd0);
        tick(1);
        check("t1_soft_c1", {31'd0, soft_rst_en}, 32'd1);
        check("t1_rst_state", {30'd0, dbg_state}, {30'd0, S_RST});
        write(2'd1, 32'd99);
        check("t1_soft_c2", {31'd0, soft_rst_en}, 32'd1);
        tick(2);
        check("t1_soft_c4", {31'd0, soft_rst_en}, 32'd1);
        tick(1);
        check("t1_soft_off", {31'd0, soft_rst_en}, 32'd0);
        check("t1_idle", {30'd0, dbg_state}, {30'd0, S_IDLE});
        rd(2'd1, rd_val); check("t1_load_ignored", rd_val, 32'd10);
        rd(2'd0, rd_val); check("t1_ctrl_en0", rd_val, 32'd6);
        write(2'd0, 32'd4);
        check("t1_irq_clr", {31'd0, irq_o}, 32'd0);

        // Regular feeding keeps the watchdog quiet
        write(2'd0, 32'd3);
        soft_seen = 1'b0;
        irq_seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick(7);
            write(2'd2, KEY);
        end
        check("t2_no_soft", {31'd0, soft_seen}, 32'd0);
        check("t2_no_irq", {31'd0, irq_seen}, 32'd0);
        rd(2'd0, rd_val); check("t2_ctrl", rd_val, 32'd3);
        write(2'd0, 32'd0);

        // Wrong key is ignored, expiry on schedule
        write(2'd0, 32'd3);
        tick(3);
        write(2'd2, 32'h1234_5678);
        rd(2'd3, rd_val); check("t3_count_bad_feed", rd_val, 32'd6);
        tick(5);
        check("t3_pre_warn", {30'd0, dbg_state}, {30'd0, S_RUN});
        tick(1);
        check("t3_warn", {30'd0, dbg_state}, {30'd0, S_WARN});
        rd(2'd2, rd_val); check("t3_feed_read", rd_val, 32'd0);

        // Feed exactly at the WARN expiry cycle wins
        tick(9);
        check("t4_warn_still", {30'd0, dbg_state}, {30'd0, S_WARN});
        write(2'd2, KEY);
        check("t4_run", {30'd0, dbg_state}, {30'd0, S_RUN});
        check("t4_no_soft", {31'd0, soft_rst_en}, 32'd0);
        rd(2'd3, rd_val); check("t4_count_reload", rd_val, 32'd10);
        rd(2'd0, rd_val); check("t4_sts_kept", rd_val, 32'd7);
        write(2'd0, 32'd7);
        check("t4_irq_clr", {31'd0, irq_o}, 32'd0);
        rd(2'd0, rd_val); check("t4_ctrl_clr", rd_val, 32'd3);
        write(2'd0, 32'd0);

        // Disable freezes COUNT; re-enable reloads; LOAD change waits for reload
        write(2'd1, 32'd50);
        write(2'd0, 32'd3);
        tick(4);
        write(2'd0, 32'd0);
        check("t5_idle", {30'd0, dbg_state}, {30'd0, S_IDLE});
        rd(2'd3, rd_val); check("t5_frozen_a", rd_val, 32'd46);
        tick(20);
        rd(2'd3, rd_val); check("t5_frozen_b", rd_val, 32'd46);
        write(2'd0, 32'd3);
        rd(2'd3, rd_val); check("t5_reenable", rd_val, 32'd50);
        write(2'd1, 32'd30);
        rd(2'd3, rd_val); check("t5_load_deferred", rd_val, 32'd48);
        write(2'd2, KEY);
        rd(2'd3, rd_val); check("t5_load_applied", rd_val, 32'd30);
        write(2'd0, 32'd0);

        // LOAD=0 expires immediately; reset during the pulse
        write(2'd1, 32'd0);
        write(2'd0, 32'd3);
        check("t6_run", {30'd0, dbg_state}, {30'd0, S_RUN});
        tick(1);
        check("t6_warn", {30'd0, dbg_state}, {30'd0, S_WARN});
        check("t6_irq", {31'd0, irq_o}, 32'd1);
        tick(1);
        check("t6_rst", {30'd0, dbg_state}, {30'd0, S_RST});
        check("t6_soft", {31'd0, soft_rst_en}, 32'd1);
        write(2'd1, 32'd77);
        rd(2'd1, rd_val); check("t6_load_ignored", rd_val, 32'd0);
        rst_n = 1'b0;
        #2;
        check("t6_no_async", {31'd0, soft_rst_en}, 32'd1);
        @(negedge clk);
        check("t6_soft_cut", {31'd0, soft_rst_en}, 32'd0);
        check("t6_idle", {30'd0, dbg_state}, {30'd0, S_IDLE});
        check("t6_irq_rst", {31'd0, irq_o}, 32'd0);
        check("t6_rdata_rst", rdata_o, 32'd0);
        rst_n = 1'b1;
        rd(2'd0, rd_val); check("t6_ctrl_rst", rd_val, 32'd0);
        rd(2'd1, rd_val); check("t6_load_rst", rd_val, 32'h00FF_FFFF);
        rd(2'd3, rd_val); check("t6_count_rst", rd_val, 32'h00FF_FFFF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
